ppu_frame_store: RTL and testbench
==================================

// Module: ppu_frame_store
// PURPOSE
// - Double-buffered framebuffer between PPU cores (writers) and vga_master (reader); one clock domain (clk).
// - Screen split in CORES_COUNT horizontal strips; core k owns strip k.
// - Read port matches vga_master's rselect/raddress/rdata interface. Write port takes rasterised pixels.
// - Bank swap only at frame start, then the new back bank is cleared before drawing resumes.
// PARAMETERS
// - VGA_WIDTH      800     pixels per line
// - VGA_HEIGHT     600     lines per frame; must be divisible by CORES_COUNT
// - CORES_COUNT    10      strips/PPU cores
// - BUFFER_ADDR_W  32      width of strip-local addresses
// - COLOR_WIDTH    16      pixel width
// - CLEAR_COLOR    '0      value written by clear sweeps
// PORTS
// - clk           in   1                     single clock (GPU clock)
// - rst           in   1                     reset: asynchronous, active-high
// - rselect       in   $clog2(CORES_COUNT)   read strip index
// - raddress      in   BUFFER_ADDR_W         read strip-local pixel index
// - rdata         out  COLOR_WIDTH           front-bank pixel, 1-cycle latency
// - w_valid       in   1                     write request
// - w_ready       out  1                     write accepted when w_valid&&w_ready
// - w_select      in   $clog2(CORES_COUNT)   write strip index
// - w_address     in   BUFFER_ADDR_W         write strip-local pixel index
// - w_data        in   COLOR_WIDTH           write pixel
// - frame_done    in   1                     pulse: back bank complete, request swap
// - swap_pending  out  1                     frame_done accepted, waiting for frame start
// - swapped       out  1                     1-cycle pulse on bank swap
// - front_bank    out  1                     bank currently displayed
// BEHAVIOUR
// - STRIP_SIZE = VGA_WIDTH*VGA_HEIGHT/CORES_COUNT; VGA_SIZE = VGA_WIDTH*VGA_HEIGHT.
// - phys = bank*VGA_SIZE + sel*STRIP_SIZE + addr; widths sized by $clog2(2*VGA_SIZE).
// - Read: rdata <= mem[phys(front_bank,rselect,raddress)] every cycle.
// - Out of range (raddress>=STRIP_SIZE or rselect>=CORES_COUNT): next rdata = 0.
// - Frame start: registered (rselect,raddress) != 0 and current == (0,0).
//   - Holding at (0,0) across stalls counts once.
//   - The first cycle after reset is not a frame start.
// - FSM states:
//   - INIT_CLEAR: reset state; sweeps all 2*VGA_SIZE words with CLEAR_COLOR, 1/cycle -> DRAW.
//   - DRAW: w_ready=1. Out-of-range writes are accepted and dropped. frame_done -> WAIT_SWAP.
//   - WAIT_SWAP: w_ready=0, swap_pending=1. On frame start: front_bank<=~front_bank, swapped=1 -> CLEAR.
//   - CLEAR: w_ready=0. Sweeps the new back bank (VGA_SIZE words) -> DRAW.
// - Reads in the frame-start cycle already use the old front bank. The swap is effective for reads the following cycle.
//   - Address (0,0) of the new frame is re-read by the reader's next cycle.
//   - One stale pixel at frame start is permitted.
// - frame_done outside DRAW is ignored. frame_done together with an accepted write: write lands, then -> WAIT_SWAP.
// - Clear writes and user writes share the single write port. No other write occurs during a sweep.
// - The read port is independent: no read stalls ever.
// - Reset values:
//   - state=INIT_CLEAR, front_bank=0, w_ready=0, swap_pending=0, swapped=0, rdata=0, clear counter=0.
// - rst mid-operation: all state is discarded immediately and a full INIT_CLEAR restarts. Memory is not assumed valid.
// STRUCTURE
// - Shared package gpu_pkg:
//   - fs_state_e {INIT_CLEAR, DRAW, WAIT_SWAP, CLEAR}
//   - function strip_size(w,h,c)
//   - color_t typedef (COLOR_WIDTH)
// - Sub-module fb_ram: simple dual-port RAM with 1 write port and 1 registered read port. Depth 2*VGA_SIZE, inferrable.
// - Top: FSM, clear counter, frame-start detector, address mapping.
// TESTING (VGA_WIDTH=8, VGA_HEIGHT=4, CORES_COUNT=2: STRIP=16, VGA_SIZE=32)
// - Reset, then idle -> w_ready=0 for exactly 64 cycles, then 1. All reads return CLEAR_COLOR. front_bank=0.
// - Write sel=1,addr=3,data=16'hABCD; frame_done; reader wraps to (0,0) -> swapped pulse 1 cycle, front_bank=1. Reading (1,3) gives 16'hABCD after 1 cycle.
// - After swap -> w_ready=0 for 32 cycles. Bank 0 reads all CLEAR_COLOR after the next swap.
// - Reader holds (0,0) for 5 cycles during WAIT_SWAP -> exactly one swap. A frame_done during WAIT_SWAP/CLEAR is ignored.
// - Write addr=16 or sel=2 -> accepted, no memory change. Reading raddress=20 -> rdata=0.
// - Assert rst during CLEAR mid-sweep -> outputs at reset values, and the 64-cycle INIT_CLEAR restarts.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions.
// Holds the frame-store FSM state type, the pixel type and the strip-size
// helper used to split the screen between PPU cores. No ports.
package gpu_pkg;

  localparam int GPU_COLOR_WIDTH = 16;

  typedef logic [GPU_COLOR_WIDTH-1:0] color_t;

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    DRAW       = 2'd1,
    WAIT_SWAP  = 2'd2,
    CLEAR      = 2'd3
  } fs_state_e;

  // Pixels owned by one core: the screen is cut into equal horizontal strips.
  function automatic int strip_size(input int w, input int h, input int c);
    return (w * h) / c;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// Written in the plain style that synthesis maps onto block RAM, so the
// storage and the read register carry no reset.
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write word address
//   wdata_i  in   write data
//   raddr_i  in   read word address
//   rdata_o  out  read data, one cycle after raddr_i
module fb_ram #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port and registered read port; a same-address read returns old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ppu_frame_store.sv
// Double-buffered framebuffer between the PPU cores and vga_master.
// Bank front_bank is displayed while the cores draw into the other bank.
// After frame_done the banks swap at the next frame start (the reader
// wrapping to strip 0, pixel 0) and the new back bank is wiped before
// drawing may continue.
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   rselect        read strip index
//   raddress       read strip-local pixel index
//   rdata          front-bank pixel, 1-cycle latency, 0 when out of range
//   w_valid/ready  write handshake (ready only while drawing)
//   w_select       write strip index
//   w_address      write strip-local pixel index
//   w_data         write pixel
//   frame_done     back bank finished, request a swap
//   swap_pending   swap requested, waiting for frame start
//   swapped        1-cycle pulse, aligned with the new front_bank value
//   front_bank     bank currently displayed
module ppu_frame_store
  import gpu_pkg::*;
#(
  parameter int VGA_WIDTH     = 800,
  parameter int VGA_HEIGHT    = 600,
  parameter int CORES_COUNT   = 10,
  parameter int BUFFER_ADDR_W = 32,
  parameter int COLOR_WIDTH   = 16,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = {COLOR_WIDTH{1'b0}},
  localparam int SEL_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         rselect,
  input  logic [BUFFER_ADDR_W-1:0] raddress,
  output logic [COLOR_WIDTH-1:0]   rdata,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [SEL_W-1:0]         w_select,
  input  logic [BUFFER_ADDR_W-1:0] w_address,
  input  logic [COLOR_WIDTH-1:0]   w_data,
  input  logic                     frame_done,
  output logic                     swap_pending,
  output logic                     swapped,
  output logic                     front_bank
);

  localparam int STRIP_SIZE = strip_size(VGA_WIDTH, VGA_HEIGHT, CORES_COUNT);
  localparam int VGA_SIZE   = VGA_WIDTH * VGA_HEIGHT;
  localparam int MEM_DEPTH  = 2 * VGA_SIZE;
  localparam int PHYS_W     = $clog2(MEM_DEPTH);

  // Physical word = bank base + strip base + offset inside the strip.
  function automatic logic [PHYS_W-1:0] phys_addr(
    input logic                     bank,
    input logic [SEL_W-1:0]         sel,
    input logic [BUFFER_ADDR_W-1:0] addr
  );
    logic [PHYS_W-1:0] base;
    base = bank ? PHYS_W'(VGA_SIZE) : {PHYS_W{1'b0}};
    return base + PHYS_W'(sel) * PHYS_W'(STRIP_SIZE) + PHYS_W'(addr);
  endfunction

  // Select is widened by one bit so CORES_COUNT itself is representable.
  function automatic logic in_range(
    input logic [SEL_W-1:0]         sel,
    input logic [BUFFER_ADDR_W-1:0] addr
  );
    return ({1'b0, sel} < (SEL_W+1)'(CORES_COUNT)) &&
           (addr < BUFFER_ADDR_W'(STRIP_SIZE));
  endfunction

  fs_state_e                state_q, state_d;
  logic                     front_bank_q, front_bank_d;
  logic [PHYS_W-1:0]        clr_cnt_q, clr_cnt_d;
  logic                     w_ready_q;
  logic                     swap_pending_q;
  logic                     swapped_q;
  logic [SEL_W-1:0]         prev_sel_q;
  logic [BUFFER_ADDR_W-1:0] prev_addr_q;
  logic                     rd_oor_q;

  logic                     frame_start_s;
  logic                     swap_s;
  logic                     ram_we_s;
  logic [PHYS_W-1:0]        ram_waddr_s;
  logic [COLOR_WIDTH-1:0]   ram_wdata_s;
  logic [PHYS_W-1:0]        rd_phys_s;
  logic [COLOR_WIDTH-1:0]   ram_rdata_s;

  // The reader arriving at (0,0) from anywhere else; holding there stays quiet.
  assign frame_start_s = ((prev_sel_q != {SEL_W{1'b0}}) ||
                          (prev_addr_q != {BUFFER_ADDR_W{1'b0}})) &&
                         (rselect == {SEL_W{1'b0}}) &&
                         (raddress == {BUFFER_ADDR_W{1'b0}});

  // Uses the pre-swap front bank, so the frame-start cycle reads the old frame.
  assign rd_phys_s = phys_addr(front_bank_q, rselect, raddress);

  // Next state, clear sweeps and the shared write port.
  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    clr_cnt_d    = clr_cnt_q;
    swap_s       = 1'b0;
    ram_we_s     = 1'b0;
    ram_waddr_s  = phys_addr(~front_bank_q, w_select, w_address);
    ram_wdata_s  = w_data;
    case (state_q)
      INIT_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_waddr_s = clr_cnt_q;
        ram_wdata_s = CLEAR_COLOR;
        if (clr_cnt_q == PHYS_W'(MEM_DEPTH - 1)) begin
          clr_cnt_d = {PHYS_W{1'b0}};
          state_d   = DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + PHYS_W'(1);
        end
      end
      DRAW: begin
        // Out-of-range writes are handshaken but never reach memory.
        ram_we_s = w_valid && in_range(w_select, w_address);
        if (frame_done) begin
          state_d = WAIT_SWAP;
        end else begin
          state_d = DRAW;
        end
      end
      WAIT_SWAP: begin
        if (frame_start_s) begin
          front_bank_d = ~front_bank_q;
          swap_s       = 1'b1;
          clr_cnt_d    = {PHYS_W{1'b0}};
          state_d      = CLEAR;
        end else begin
          state_d = WAIT_SWAP;
        end
      end
      CLEAR: begin
        // front_bank_q already holds the new front; wipe the other bank.
        ram_we_s    = 1'b1;
        ram_waddr_s = (front_bank_q ? {PHYS_W{1'b0}} : PHYS_W'(VGA_SIZE)) + clr_cnt_q;
        ram_wdata_s = CLEAR_COLOR;
        if (clr_cnt_q == PHYS_W'(VGA_SIZE - 1)) begin
          clr_cnt_d = {PHYS_W{1'b0}};
          state_d   = DRAW;
        end else begin
          clr_cnt_d = clr_cnt_q + PHYS_W'(1);
        end
      end
      default: begin
        clr_cnt_d = {PHYS_W{1'b0}};
        state_d   = INIT_CLEAR;
      end
    endcase
  end

  // State, status outputs, reader history and read range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= INIT_CLEAR;
      front_bank_q   <= 1'b0;
      clr_cnt_q      <= {PHYS_W{1'b0}};
      w_ready_q      <= 1'b0;
      swap_pending_q <= 1'b0;
      swapped_q      <= 1'b0;
      prev_sel_q     <= {SEL_W{1'b0}};
      prev_addr_q    <= {BUFFER_ADDR_W{1'b0}};
      rd_oor_q       <= 1'b1;  // forces rdata to 0 until the first real read
    end else begin
      state_q        <= state_d;
      front_bank_q   <= front_bank_d;
      clr_cnt_q      <= clr_cnt_d;
      w_ready_q      <= (state_d == DRAW);
      swap_pending_q <= (state_d == WAIT_SWAP);
      swapped_q      <= swap_s;
      prev_sel_q     <= rselect;
      prev_addr_q    <= raddress;
      rd_oor_q       <= !in_range(rselect, raddress);
    end
  end

  fb_ram #(
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (PHYS_W),
    .DATA_W (COLOR_WIDTH)
  ) u_fb_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .raddr_i (rd_phys_s),
    .rdata_o (ram_rdata_s)
  );

  assign rdata        = rd_oor_q ? {COLOR_WIDTH{1'b0}} : ram_rdata_s;
  assign w_ready      = w_ready_q;
  assign swap_pending = swap_pending_q;
  assign swapped      = swapped_q;
  assign front_bank   = front_bank_q;

endmodule

// File: tb/tb_ppu_frame_store.sv
module tb_ppu_frame_store;

  localparam logic [15:0] CC = 16'h5A5A;

  logic        clk;
  logic        rst;
  logic [0:0]  rselect;
  logic [31:0] raddress;
  logic [15:0] rdata;
  logic        w_valid;
  logic        w_ready;
  logic [0:0]  w_select;
  logic [31:0] w_address;
  logic [15:0] w_data;
  logic        frame_done;
  logic        swap_pending;
  logic        swapped;
  logic        front_bank;

  int total;
  int bad;

  ppu_frame_store #(
    .VGA_WIDTH     (8),
    .VGA_HEIGHT    (4),
    .CORES_COUNT   (2),
    .BUFFER_ADDR_W (32),
    .COLOR_WIDTH   (16),
    .CLEAR_COLOR   (CC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rselect      (rselect),
    .raddress     (raddress),
    .rdata        (rdata),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_select     (w_select),
    .w_address    (w_address),
    .w_data       (w_data),
    .frame_done   (frame_done),
    .swap_pending (swap_pending),
    .swapped      (swapped),
    .front_bank   (front_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [0:0] s, input logic [31:0] a, input logic [15:0] exp, input string tag);
    rselect  = s;
    raddress = a;
    step();
    check_eq(tag, 32'(rdata), 32'(exp));
  endtask

  task automatic wr(input logic [0:0] s, input logic [31:0] a, input logic [15:0] d);
    check_eq("wr_ready", 32'(w_ready), 32'd1);
    w_valid   = 1'b1;
    w_select  = s;
    w_address = a;
    w_data    = d;
    step();
    w_valid   = 1'b0;
  endtask

  task automatic count_init(input string tag);
    int n;
    n = 0;
    while (!w_ready && n < 200) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n), 32'd64);
  endtask

  task automatic swap_frame(input logic exp_front);
    int pulses;
    rselect  = 1'b1;
    raddress = 32'd15;
    step();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check_eq("sw_pending", 32'(swap_pending), 32'd1);
    rselect  = 1'b0;
    raddress = 32'd0;
    pulses   = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (swapped) pulses++;
    end
    check_eq("sw_pulses", 32'(pulses), 32'd1);
    check_eq("sw_front", 32'(front_bank), 32'(exp_front));
    check_eq("sw_ready", 32'(w_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    rselect    = 1'b0;
    raddress   = 32'd0;
    w_valid    = 1'b0;
    w_select   = 1'b0;
    w_address  = 32'd0;
    w_data     = 16'h0000;
    frame_done = 1'b0;
    step();
    step();
    check_eq("rst_ready", 32'(w_ready), 32'd0);
    check_eq("rst_pending", 32'(swap_pending), 32'd0);
    check_eq("rst_swapped", 32'(swapped), 32'd0);
    check_eq("rst_rdata", 32'(rdata), 32'd0);
    check_eq("rst_front", 32'(front_bank), 32'd0);

    rst = 1'b0;
    count_init("init_cycles");
    check_eq("init_front", 32'(front_bank), 32'd0);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        rd(1'(s), 32'(a), CC, "init_rd");
      end
    end

    // First swap, timed in detail.
    wr(1'b1, 32'd3, 16'hABCD);
    rd(1'b1, 32'd3, CC, "front0_untouched");
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check_eq("ws_pending", 32'(swap_pending), 32'd1);
    check_eq("ws_ready", 32'(w_ready), 32'd0);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check_eq("ws_still_pending", 32'(swap_pending), 32'd1);
    check_eq("ws_no_swap", 32'(front_bank), 32'd0);
    rselect  = 1'b0;
    raddress = 32'd0;
    step();
    check_eq("swap_pulse", 32'(swapped), 32'd1);
    check_eq("swap_front", 32'(front_bank), 32'd1);
    check_eq("swap_pending_clr", 32'(swap_pending), 32'd0);
    n = 1;
    step();
    check_eq("swap_pulse_end", 32'(swapped), 32'd0);
    frame_done = 1'b1;
    while (!w_ready && n < 100) begin
      step();
      frame_done = 1'b0;
      n++;
    end
    frame_done = 1'b0;
    check_eq("clear_cycles", 32'(n), 32'd32);
    step();
    check_eq("clear_fd_ignored", 32'(swap_pending), 32'd0);
    rd(1'b1, 32'd3, 16'hABCD, "rd_written");
    rd(1'b1, 32'd4, CC, "rd_neighbour");
    rd(1'b0, 32'd20, 16'h0000, "rd_oor");

    // Back bank is 0: one legal write plus three that must be dropped.
    wr(1'b0, 32'd5, 16'h1234);
    wr(1'b0, 32'd16, 16'hDEAD);
    wr(1'b1, 32'd16, 16'hBEEF);
    wr(1'b0, 32'd32, 16'hF00D);
    rd(1'b0, 32'd0, CC, "oor_wr_alias_front");

    swap_frame(1'b0);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        rd(1'(s), 32'(a), (s == 0 && a == 5) ? 16'h1234 : CC, "bank0_rd");
      end
    end

    swap_frame(1'b1);
    rd(1'b1, 32'd3, CC, "bank1_cleared");
    swap_frame(1'b0);

    // Reset in the middle of the sweep that follows a swap to bank 1.
    rselect  = 1'b1;
    raddress = 32'd15;
    step();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    rselect  = 1'b0;
    raddress = 32'd0;
    for (int i = 0; i < 10; i++) step();
    check_eq("mid_clear_ready", 32'(w_ready), 32'd0);
    check_eq("mid_clear_front", 32'(front_bank), 32'd1);
    check_eq("mid_clear_rdata", 32'(rdata), 32'(CC));
    rst = 1'b1;
    #1;
    check_eq("rst2_ready", 32'(w_ready), 32'd0);
    check_eq("rst2_pending", 32'(swap_pending), 32'd0);
    check_eq("rst2_swapped", 32'(swapped), 32'd0);
    check_eq("rst2_rdata", 32'(rdata), 32'd0);
    check_eq("rst2_front", 32'(front_bank), 32'd0);
    step();
    step();
    rst = 1'b0;
    count_init("reinit_cycles");
    rd(1'b0, 32'd5, CC, "reinit_wiped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
